// File: rtl/max_sweep_ctrl.sv
// rtl/max_sweep_ctrl.sv - max-score sweep sequencing controller
//
// Purpose: for each alignment job, clear the max registers, then walk the
// score matrix tile by tile issuing steps to the PE array. wr_en_max is timed
// to PE output latency. After the pipe drains, the final max score and its
// coordinates are returned on a valid/ready result port.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, len_a, len_b          job start (IDLE only) and sequence lengths
//   busy                         high outside IDLE
//   step_valid/step_ready        step handshake, with tile_row_base/tile_col_base
//   max_clr, wr_en_max           max-register clear and write enable
//   max_score_in/row_in/col_in   current max-register contents
//   res_valid/res_ready          result handshake, with res_score/res_row/res_col
//
// Optional build macro MAX_EARLY_EXIT_EN adds the max_thresh input and the
// res_early output, which end a job early once the running max reaches the
// threshold.
module max_sweep_ctrl #(
  parameter int ROW_BITS_WIDTH = 8,
  parameter int COL_BITS_WIDTH = 8,
  parameter int SCORE_WIDTH    = 10,
  parameter int TILE_ROWS      = 16,
  parameter int TILE_COLS      = 4,
  parameter int PIPE_LAT       = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ROW_BITS_WIDTH-1:0] len_a,
  input  logic [COL_BITS_WIDTH-1:0] len_b,
  output logic                      busy,
  output logic                      step_valid,
  input  logic                      step_ready,
  output logic [ROW_BITS_WIDTH-1:0] tile_row_base,
  output logic [COL_BITS_WIDTH-1:0] tile_col_base,
  output logic                      max_clr,
  output logic                      wr_en_max,
  input  logic [SCORE_WIDTH-1:0]    max_score_in,
  input  logic [ROW_BITS_WIDTH-1:0] max_row_in,
  input  logic [COL_BITS_WIDTH-1:0] max_col_in,
`ifdef MAX_EARLY_EXIT_EN
  input  logic [SCORE_WIDTH-1:0]    max_thresh,
  output logic                      res_early,
`endif
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [SCORE_WIDTH-1:0]    res_score,
  output logic [ROW_BITS_WIDTH-1:0] res_row,
  output logic [COL_BITS_WIDTH-1:0] res_col
);

  localparam int RSH = $clog2(TILE_ROWS);
  localparam int CSH = $clog2(TILE_COLS);
  localparam logic [ROW_BITS_WIDTH-1:0] ROW_MASK = ROW_BITS_WIDTH'(TILE_ROWS - 1);
  localparam logic [COL_BITS_WIDTH-1:0] COL_MASK = COL_BITS_WIDTH'(TILE_COLS - 1);
  localparam logic [ROW_BITS_WIDTH-1:0] ROW_ONE  = ROW_BITS_WIDTH'(1);
  localparam logic [COL_BITS_WIDTH-1:0] COL_ONE  = COL_BITS_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_RESULT} state_t;

  state_t                    state_q, state_d;
  logic [ROW_BITS_WIDTH-1:0] nrt_q, nrt_d, row_tile_q, row_tile_d;
  logic [COL_BITS_WIDTH-1:0] nct_q, nct_d, col_tile_q, col_tile_d;
  logic [PIPE_LAT-1:0]       pipe_q, pipe_d;
  logic                      busy_q, busy_d, step_valid_q, step_valid_d;
  logic                      max_clr_q, max_clr_d, res_valid_q, res_valid_d;
  logic [SCORE_WIDTH-1:0]    res_score_q, res_score_d;
  logic [ROW_BITS_WIDTH-1:0] res_row_q, res_row_d;
  logic [COL_BITS_WIDTH-1:0] res_col_q, res_col_d;
  logic                      fire, last_tile, early_hit;
`ifdef MAX_EARLY_EXIT_EN
  logic [SCORE_WIDTH-1:0]    thresh_q, thresh_d;
  logic                      early_q, early_d;
`endif

  always_comb begin
    fire      = step_valid_q & step_ready;
    last_tile = (row_tile_q == nrt_q - ROW_ONE) && (col_tile_q == nct_q - COL_ONE);
    early_hit = 1'b0;
`ifdef MAX_EARLY_EXIT_EN
    early_hit = (thresh_q != '0) && (max_score_in >= thresh_q);
    thresh_d  = thresh_q;
    early_d   = early_q;
`endif
    state_d     = state_q;
    nrt_d       = nrt_q;
    nct_d       = nct_q;
    row_tile_d  = row_tile_q;
    col_tile_d  = col_tile_q;
    res_score_d = res_score_q;
    res_row_d   = res_row_q;
    res_col_d   = res_col_q;
    // pipe[0] takes this cycle's fire; each bit ages one cycle per clock.
    pipe_d      = (pipe_q << 1) | PIPE_LAT'(fire);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          // Ceiling division: whole tiles plus one if any remainder.
          nrt_d      = (len_a >> RSH) + ROW_BITS_WIDTH'(|(len_a & ROW_MASK));
          nct_d      = (len_b >> CSH) + COL_BITS_WIDTH'(|(len_b & COL_MASK));
          row_tile_d = '0;
          col_tile_d = '0;
`ifdef MAX_EARLY_EXIT_EN
          thresh_d   = max_thresh;
          early_d    = 1'b0;
`endif
        end
      end
      S_CLEAR: begin
        if (nrt_q == '0 || nct_q == '0) begin
          state_d     = S_RESULT;
          res_score_d = '0;
          res_row_d   = '0;
          res_col_d   = '0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          if (last_tile || early_hit) begin
            state_d = S_DRAIN;
`ifdef MAX_EARLY_EXIT_EN
            if (early_hit) early_d = 1'b1;
`endif
          end else if (col_tile_q == nct_q - COL_ONE) begin
            col_tile_d = '0;
            row_tile_d = row_tile_q + ROW_ONE;
          end else begin
            col_tile_d = col_tile_q + COL_ONE;
          end
        end
      end
      S_DRAIN: begin
        // Checked one cycle after the last wr_en_max, so the max registers
        // already hold the final values.
        if (pipe_q == '0) begin
          state_d     = S_RESULT;
          res_score_d = max_score_in;
          res_row_d   = max_row_in;
          res_col_d   = max_col_in;
        end
      end
      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state.
    busy_d       = (state_d != S_IDLE);
    step_valid_d = (state_d == S_ISSUE);
    max_clr_d    = (state_d == S_CLEAR);
    res_valid_d  = (state_d == S_RESULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      nrt_q        <= '0;
      nct_q        <= '0;
      row_tile_q   <= '0;
      col_tile_q   <= '0;
      pipe_q       <= '0;
      busy_q       <= 1'b0;
      step_valid_q <= 1'b0;
      max_clr_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_score_q  <= '0;
      res_row_q    <= '0;
      res_col_q    <= '0;
`ifdef MAX_EARLY_EXIT_EN
      thresh_q     <= '0;
      early_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      nrt_q        <= nrt_d;
      nct_q        <= nct_d;
      row_tile_q   <= row_tile_d;
      col_tile_q   <= col_tile_d;
      pipe_q       <= pipe_d;
      busy_q       <= busy_d;
      step_valid_q <= step_valid_d;
      max_clr_q    <= max_clr_d;
      res_valid_q  <= res_valid_d;
      res_score_q  <= res_score_d;
      res_row_q    <= res_row_d;
      res_col_q    <= res_col_d;
`ifdef MAX_EARLY_EXIT_EN
      thresh_q     <= thresh_d;
      early_q      <= early_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign step_valid    = step_valid_q;
  assign tile_row_base = row_tile_q << RSH;
  assign tile_col_base = col_tile_q << CSH;
  assign max_clr       = max_clr_q;
  assign wr_en_max     = pipe_q[PIPE_LAT-1];
  assign res_valid     = res_valid_q;
  assign res_score     = res_score_q;
  assign res_row       = res_row_q;
  assign res_col       = res_col_q;
`ifdef MAX_EARLY_EXIT_EN
  assign res_early     = early_q;
`endif

endmodule
